// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath mux selects, ALU commands and the ARM condition evaluator.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DATA = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv is packed {N,Z,C,V}; the 1111 encoding is treated as always.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register plus the condition evaluator for the current instruction.
// flagWr[1] loads N,Z and flagWr[0] loads C,V from the ALU flags at the clock edge.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluFlags,
  input  logic [1:0] flagWr,
  output logic       condEx
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (flagWr[1]) flags_d[3:2] = aluFlags[3:2];
    if (flagWr[0]) flags_d[1:0] = aluFlags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign condEx = cond_check(cond, flags_q);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the multicycle ARM-subset datapath: sequences each instruction,
// drives mux selects/enables and gates every architectural write with condExR.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] Rd,
  input  logic [3:0] aluFlags,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memW,
  output logic       irWrite,
  output logic       regW,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [1:0] immSrc,
  output logic [1:0] regSrc,
  output logic [1:0] aluControl,
  output logic       illegal,
  output logic [3:0] stateDbg
);

  state_t     state_q, state_d;
  logic       condExR_q, condExR_d;
  logic       condEx;
  logic [1:0] flagWr;
  logic [1:0] aluDec;
  logic [1:0] flagKind;
  logic       pcw_c, memw_c, irw_c, regw_c;

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .aluFlags (aluFlags),
    .flagWr   (flagWr),
    .condEx   (condEx)
  );

  // flagKind: 11 = full NZCV, 10 = NZ only, 00 = no update
  always_comb begin
    aluDec   = ALU_ADD;
    flagKind = 2'b00;
    case (funct[4:1])
      CMD_ADD: begin aluDec = ALU_ADD; flagKind = 2'b11; end
      CMD_SUB: begin aluDec = ALU_SUB; flagKind = 2'b11; end
      CMD_AND: begin aluDec = ALU_AND; flagKind = 2'b10; end
      CMD_ORR: begin aluDec = ALU_ORR; flagKind = 2'b10; end
      default: begin aluDec = ALU_ADD; flagKind = 2'b00; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    condExR_d  = condExR_q;
    pcw_c      = 1'b0;
    memw_c     = 1'b0;
    irw_c      = 1'b0;
    regw_c     = 1'b0;
    adrSrc     = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = SRCB_RD2;
    resultSrc  = RES_ALUOUT;
    aluControl = ALU_ADD;
    illegal    = 1'b0;
    flagWr     = 2'b00;
    case (state_q)
      FETCH: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURES;
        irw_c     = memReady;
        pcw_c     = memReady;
        if (memReady) state_d = DECODE;
      end
      DECODE: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURES;
        condExR_d = condEx;
        case (op)
          OP_MEM:  state_d = MEMADR;
          OP_DATA: state_d = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        aluSrcB = SRCB_IMM;
        state_d = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrSrc = 1'b1;
        if (memReady) state_d = MEMWB;
      end
      MEMWRITE: begin
        adrSrc = 1'b1;
        memw_c = condExR_q;
        if (memReady) state_d = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        aluSrcB    = (state_q == EXECUTEI) ? SRCB_IMM : SRCB_RD2;
        aluControl = aluDec;
        if (condExR_q && funct[0]) flagWr = flagKind;
        state_d    = ALUWB;
      end
      MEMWB, ALUWB: begin
        // Loads and ALU ops share write-back; Rd==15 redirects the result into the PC.
        resultSrc = (state_q == MEMWB) ? RES_DATA : RES_ALUOUT;
        if (Rd == 4'd15) pcw_c  = condExR_q;
        else             regw_c = condExR_q;
        state_d = FETCH;
      end
      BRANCH: begin
        aluSrcB   = SRCB_IMM;
        resultSrc = RES_ALURES;
        pcw_c     = condExR_q;
        state_d   = FETCH;
      end
      UNKNOWN: begin
        illegal = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      condExR_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      condExR_q <= condExR_d;
    end
  end

  // Enables are forced low for the whole time reset is asserted, not just after the edge.
  assign pcWrite  = pcw_c  & ~reset;
  assign memW     = memw_c & ~reset;
  assign irWrite  = irw_c  & ~reset;
  assign regW     = regw_c & ~reset;
  assign immSrc   = op;
  assign regSrc   = {op == OP_MEM, op == OP_BR};
  assign stateDbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expected output words go through a scoreboard queue.
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] Rd;
  logic [3:0] aluFlags;
  logic       memReady;
  logic       pcWrite, adrSrc, memW, irWrite, regW, aluSrcA, illegal;
  logic [1:0] aluSrcB, resultSrc, immSrc, regSrc, aluControl;
  logic [3:0] stateDbg;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [20:0] exp;
  } sb_item_t;
  sb_item_t sb[$];

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .Rd(Rd),
    .aluFlags(aluFlags), .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
    .memW(memW), .irWrite(irWrite), .regW(regW), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .resultSrc(resultSrc), .immSrc(immSrc), .regSrc(regSrc), .aluControl(aluControl),
    .illegal(illegal), .stateDbg(stateDbg)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] ex(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic sa, input logic [1:0] sb_sel,
                                     input logic [1:0] rs, input logic [1:0] ac, input logic ill);
    logic [1:0] rsrc;
    rsrc = {op == 2'b01, op == 2'b10};
    return {st, pcw, adr, mw, irw, rw, sa, sb_sel, rs, op, rsrc, ac, ill};
  endfunction

  function automatic logic [20:0] fetchE(input logic en);
    return ex(FETCH, en, 1'b0, 1'b0, en, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0);
  endfunction

  function automatic logic [20:0] decodeE();
    return ex(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0);
  endfunction

  function automatic logic [20:0] observed();
    return {stateDbg, pcWrite, adrSrc, memW, irWrite, regW, aluSrcA, aluSrcB,
            resultSrc, immSrc, regSrc, aluControl, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [20:0] e);
    sb_item_t it;
    sb.push_back('{tag, e});
    @(negedge clk);
    it = sb.pop_front();
    check(it.tag, {11'd0, observed()}, {11'd0, it.exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cond = 4'hE; op = 2'b00; funct = 6'b0; Rd = 4'd0;
    aluFlags = 4'b0; memReady = 1'b1;
    #2;
    step("rst_fetch", fetchE(1'b0));
    reset = 1'b0; memReady = 1'b0;
    step("fetch_hold", fetchE(1'b0));

    // ADD R1,R2,R3
    memReady = 1'b1; funct = 6'b001000; Rd = 4'd1;
    step("add_fetch", fetchE(1'b1));
    step("add_decode", decodeE());
    step("add_exec", ex(EXECUTER, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    step("add_wb", ex(ALUWB, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));

    // SUBS R0,R0,#1 giving zero (Z=1, C=1)
    funct = 6'b100101; Rd = 4'd0; aluFlags = 4'b0110;
    step("subs_fetch", fetchE(1'b1));
    step("subs_decode", decodeE());
    step("subs_exec", ex(EXECUTEI, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0));
    aluFlags = 4'b1001;
    step("subs_wb", ex(ALUWB, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));

    // BEQ taken; funct bits mimic an S-type cmd and must not touch flags
    cond = 4'b0000; op = 2'b10; funct = 6'b100101;
    step("beq_fetch", fetchE(1'b1));
    step("beq_decode", decodeE());
    step("beq_taken", ex(BRANCH, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0));
    check("flags_subs", {28'd0, dut.u_cond.flags_q}, 32'h6);

    // ORRS clears Z, leaves C (V on the ALU must be ignored)
    cond = 4'hE; op = 2'b00; funct = 6'b011001; Rd = 4'd4; aluFlags = 4'b0001;
    step("orrs_fetch", fetchE(1'b1));
    step("orrs_decode", decodeE());
    step("orrs_exec", ex(EXECUTER, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0));
    step("orrs_wb", ex(ALUWB, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
    cond = 4'b0000; op = 2'b10;
    step("beq2_fetch", fetchE(1'b1));
    step("beq2_decode", decodeE());
    step("beq_not_taken", ex(BRANCH, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0));
    cond = 4'b0010;
    step("bcs_fetch", fetchE(1'b1));
    step("bcs_decode", decodeE());
    step("bcs_taken", ex(BRANCH, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0));

    // STR with memReady low for 3 cycles
    cond = 4'hE; op = 2'b01; funct = 6'b011000; Rd = 4'd2;
    step("str_fetch", fetchE(1'b1));
    step("str_decode", decodeE());
    step("str_memadr", ex(MEMADR, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    memReady = 1'b0;
    for (int i = 0; i < 3; i++)
      step("str_hold", ex(MEMWRITE, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    memReady = 1'b1;
    step("str_done", ex(MEMWRITE, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));

    // LDR PC,[...]
    funct = 6'b011001; Rd = 4'd15;
    step("ldr_fetch", fetchE(1'b1));
    step("ldr_decode", decodeE());
    step("ldr_memadr", ex(MEMADR, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    step("ldr_memread", ex(MEMREAD, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    step("ldr_wb_pc", ex(MEMWB, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0));

    // SUBS again to set Z, then ANDNE must be squashed
    op = 2'b00; funct = 6'b100101; Rd = 4'd0; aluFlags = 4'b0110;
    step("subs2_fetch", fetchE(1'b1));
    step("subs2_decode", decodeE());
    step("subs2_exec", ex(EXECUTEI, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0));
    step("subs2_wb", ex(ALUWB, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
    cond = 4'b0001; funct = 6'b000001; Rd = 4'd3; aluFlags = 4'b1000;
    step("andne_fetch", fetchE(1'b1));
    step("andne_decode", decodeE());
    step("andne_exec", ex(EXECUTER, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0));
    step("andne_wb", ex(ALUWB, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    check("flags_andne", {28'd0, dut.u_cond.flags_q}, 32'h6);
    cond = 4'b0000; op = 2'b10;
    step("beq3_fetch", fetchE(1'b1));
    step("beq3_decode", decodeE());
    step("beq3_taken", ex(BRANCH, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0));

    // Illegal op
    cond = 4'hE; op = 2'b11; funct = 6'b000001;
    step("ill_fetch", fetchE(1'b1));
    step("ill_decode", decodeE());
    step("ill_unknown", ex(UNKNOWN, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1));

    // LDR stalled in MEMREAD, then asynchronous reset
    op = 2'b01; funct = 6'b011001; Rd = 4'd5;
    step("ill_next_fetch", fetchE(1'b1));
    step("ldr2_decode", decodeE());
    step("ldr2_memadr", ex(MEMADR, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    memReady = 1'b0;
    step("ldr2_hold", ex(MEMREAD, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    memReady = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_state", {28'd0, stateDbg}, {28'd0, FETCH});
    check("rst_async_en", {28'd0, pcWrite, memW, irWrite, regW}, 32'h0);
    step("rst_mid", fetchE(1'b0));
    check("flags_reset", {28'd0, dut.u_cond.flags_q}, 32'h0);
    reset = 1'b0; cond = 4'b0000; op = 2'b10; funct = 6'b0;
    step("post_rst_fetch", fetchE(1'b1));
    step("post_rst_decode", decodeE());
    step("post_rst_beq", ex(BRANCH, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
